dreg_universal: RTL

//   Parametrised clocked storage element that succeeds the single-bit gated D latch.

---
 rtl/dreg_universal.sv | 90 +++++++++
 1 files changed

// File: rtl/dreg_universal.sv
// WIDTH-bit clocked register with hold, parallel load, shift and rotate.
// Qb and Zero are decoded from the stored value; Qa and SerOut are registered.
module dreg_universal #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter bit               ROTATE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Enable,
    input  logic [1:0]       Mode,
    input  logic             Dir,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic             SerOut,
    output logic             Zero
);

    logic [WIDTH-1:0] qa_q;
    logic [WIDTH-1:0] qa_d;
    logic             serout_q;
    logic             serout_d;

    // Next-state selection; Mode/Dir/D are only looked at when Enable is high,
    // so unknown values on them while disabled cannot reach the register.
    always_comb begin
        qa_d     = qa_q;
        serout_d = serout_q;
        if (Enable) begin
            case (Mode)
                2'b00: begin
                    qa_d     = qa_q;
                    serout_d = serout_q;
                end
                2'b01: begin
                    qa_d     = D;
                    serout_d = 1'b0;
                end
                2'b10: begin
                    if (Dir) begin
                        qa_d     = {SerInR, qa_q[WIDTH-1:1]};
                        serout_d = qa_q[0];
                    end else begin
                        qa_d     = {qa_q[WIDTH-2:0], SerInL};
                        serout_d = qa_q[WIDTH-1];
                    end
                end
                2'b11: begin
                    if (!ROTATE_EN) begin
                        qa_d     = qa_q;
                        serout_d = serout_q;
                    end else if (Dir) begin
                        qa_d     = {qa_q[0], qa_q[WIDTH-1:1]};
                        serout_d = qa_q[0];
                    end else begin
                        qa_d     = {qa_q[WIDTH-2:0], qa_q[WIDTH-1]};
                        serout_d = qa_q[WIDTH-1];
                    end
                end
                default: begin
                    qa_d     = qa_q;
                    serout_d = serout_q;
                end
            endcase
        end else begin
            qa_d     = qa_q;
            serout_d = serout_q;
        end
    end

    // State register; reset wins over Enable and Mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            qa_q     <= RST_VAL;
            serout_q <= 1'b0;
        end else begin
            qa_q     <= qa_d;
            serout_q <= serout_d;
        end
    end

    assign Qa     = qa_q;
    assign Qb     = ~qa_q;
    assign SerOut = serout_q;
    assign Zero   = (qa_q == {WIDTH{1'b0}});

endmodule
